// File: rtl/reg_transfer_seq.sv
// Bus-side register-transfer sequencer: queues MOV/HALF/SWAP requests and
// expands each into per-register low/high op-line patterns, one bus cycle per clock.
package reg_transfer_pkg;
  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'b00,
    REG_OP_READ  = 2'b01,
    REG_OP_WRITE = 2'b10
  } reg_op_t;

  typedef enum logic [1:0] {
    CMD_MOV  = 2'b00,
    CMD_HALF = 2'b01,
    CMD_SWAP = 2'b10,
    CMD_ILL  = 2'b11
  } req_cmd_t;
endpackage

module reg_transfer_seq
  import reg_transfer_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 3,
  parameter int DEPTH    = 4,
  parameter int TEMP_REG = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_cmd,
  input  logic [IDX_W-1:0]       req_src,
  input  logic [IDX_W-1:0]       req_dst,
  input  logic                   req_src_hi,
  input  logic                   req_dst_hi,
  output reg_op_t [NUM_REGS-1:0] op_low,
  output reg_op_t [NUM_REGS-1:0] op_high,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] TEMP_IDX = IDX_W'(TEMP_REG);

  typedef struct packed {
    logic [1:0]       cmd;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
    logic             src_hi;
    logic             dst_hi;
  } req_t;

  typedef enum logic [2:0] {IDLE, XFER, SWAP1, SWAP2, SWAP3} state_t;

  state_t           state, nxt_state;
  req_t             mem [DEPTH];
  req_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [IDX_W-1:0] cur_src, cur_dst, nxt_src, nxt_dst;
  logic             nxt_done, nxt_err, illegal;
  logic [NUM_REGS-1:0]   wr_lo, wr_hi, rd_lo, rd_hi;
  reg_op_t [NUM_REGS-1:0] nxt_low, nxt_high;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] m;
    for (int r = 0; r < NUM_REGS; r++) m[r] = (int'(idx) == r);
    return m;
  endfunction

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign busy      = (state != IDLE) || !empty;
  assign head      = mem[rd_ptr];

  // NOTE: request storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd: req_cmd, src: req_src, dst: req_dst,
                               src_hi: req_src_hi, dst_hi: req_dst_hi};
  end

  assign illegal = (head.cmd == CMD_ILL)
                || (int'(head.src) >= NUM_REGS) || (int'(head.dst) >= NUM_REGS)
                || ((head.cmd == CMD_SWAP) && ((head.src == TEMP_IDX) ||
                    (head.dst == TEMP_IDX) || (head.src == head.dst)));

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    nxt_state = IDLE;
    nxt_src   = cur_src;
    nxt_dst   = cur_dst;
    nxt_done  = 1'b0;
    nxt_err   = 1'b0;
    pop       = 1'b0;
    wr_lo     = '0;
    wr_hi     = '0;
    rd_lo     = '0;
    rd_hi     = '0;

    unique case (state)
      SWAP1: begin
        nxt_state = SWAP2;
        wr_lo = onehot(cur_dst);
        wr_hi = onehot(cur_dst);
        rd_lo = onehot(cur_src);
        rd_hi = onehot(cur_src);
      end
      SWAP2: begin
        nxt_state = SWAP3;
        nxt_done  = 1'b1;
        wr_lo = onehot(TEMP_IDX);
        wr_hi = onehot(TEMP_IDX);
        rd_lo = onehot(cur_dst);
        rd_hi = onehot(cur_dst);
      end
      default: begin
        // IDLE, XFER and SWAP3 all end a request, so the next one loads without a gap.
        if (!empty) begin
          pop       = 1'b1;
          nxt_state = XFER;
          nxt_src   = head.src;
          nxt_dst   = head.dst;
          if (illegal) begin
            nxt_err = 1'b1;
          end else begin
            unique case (head.cmd)
              CMD_MOV: begin
                nxt_done = 1'b1;
                if (head.src != head.dst) begin
                  wr_lo = onehot(head.src);
                  wr_hi = onehot(head.src);
                  rd_lo = onehot(head.dst);
                  rd_hi = onehot(head.dst);
                end
              end
              CMD_HALF: begin
                nxt_done = 1'b1;
                if (!((head.src == head.dst) && (head.src_hi == head.dst_hi))) begin
                  if (head.src_hi) wr_hi = onehot(head.src);
                  else             wr_lo = onehot(head.src);
                  if (head.dst_hi) rd_hi = onehot(head.dst);
                  else             rd_lo = onehot(head.dst);
                end
              end
              CMD_SWAP: begin
                nxt_state = SWAP1;
                wr_lo = onehot(head.src);
                wr_hi = onehot(head.src);
                rd_lo = onehot(TEMP_IDX);
                rd_hi = onehot(TEMP_IDX);
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    for (int r = 0; r < NUM_REGS; r++) begin
      nxt_low[r]  = wr_lo[r] ? REG_OP_WRITE : (rd_lo[r] ? REG_OP_READ : REG_OP_NONE);
      nxt_high[r] = wr_hi[r] ? REG_OP_WRITE : (rd_hi[r] ? REG_OP_READ : REG_OP_NONE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cur_src <= '0;
      cur_dst <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        op_low[r]  <= REG_OP_NONE;
        op_high[r] <= REG_OP_NONE;
      end
    end else begin
      state   <= nxt_state;
      cur_src <= nxt_src;
      cur_dst <= nxt_dst;
      done    <= nxt_done;
      err     <= nxt_err;
      op_low  <= nxt_low;
      op_high <= nxt_high;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_transfer_seq.sv
// Directed bench for reg_transfer_seq with a small 8-bit split-register bus model
// that applies the op lines at each negedge so data outcomes can be checked too.
module tb_reg_transfer_seq;
  import reg_transfer_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_cmd = 2'b00;
  logic [2:0]     req_src = 3'd0;
  logic [2:0]     req_dst = 3'd0;
  logic           req_src_hi = 1'b0;
  logic           req_dst_hi = 1'b0;
  reg_op_t [3:0]  op_low, op_high;
  logic           busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] regs [4];

  reg_transfer_seq #(.NUM_REGS(4), .IDX_W(3), .DEPTH(4), .TEMP_REG(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_src(req_src), .req_dst(req_dst),
    .req_src_hi(req_src_hi), .req_dst_hi(req_dst_hi),
    .op_low(op_low), .op_high(op_high), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register model: a lone WRITE half is mirrored onto both bus halves.
  always @(negedge clk) begin
    logic [7:0] bus;
    bus = 8'h00;
    for (int r = 0; r < 4; r++) begin
      if (op_low[r] == REG_OP_WRITE && op_high[r] == REG_OP_WRITE) bus = regs[r];
      else if (op_low[r] == REG_OP_WRITE) bus = {regs[r][3:0], regs[r][3:0]};
      else if (op_high[r] == REG_OP_WRITE) bus = {regs[r][7:4], regs[r][7:4]};
    end
    for (int r = 0; r < 4; r++) begin
      if (op_low[r] == REG_OP_READ)  regs[r][3:0] = bus[3:0];
      if (op_high[r] == REG_OP_READ) regs[r][7:4] = bus[7:4];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [2:0] s, input logic [2:0] d,
                       input logic sh, input logic dh);
    req_valid  = 1'b1;
    req_cmd    = cmd;
    req_src    = s;
    req_dst    = d;
    req_src_hi = sh;
    req_dst_hi = dh;
  endtask

  // Presents one request for one edge (FIFO assumed not full), then drops valid.
  task automatic send(input logic [1:0] cmd, input logic [2:0] s, input logic [2:0] d,
                      input logic sh, input logic dh);
    drive(cmd, s, d, sh, dh);
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if ({op_low, op_high} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_ops: got %h expected 0000", {op_low, op_high});
    end
    vectors++;
    if ({busy, done, err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: busy/done/err got %b expected 000", {busy, done, err});
    end
    step();
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: ready/busy got %b%b expected 10", req_ready, busy);
    end
  endtask

  task automatic test_mov();
    send(CMD_MOV, 3'd1, 3'd2, 1'b0, 1'b0);
    vectors++;
    if ({op_low, op_high} !== 16'h0000 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mov_queued: ops %h busy %b expected 0000 1", {op_low, op_high}, busy);
    end
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h1818 || done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL mov_cycle: ops %h done %b err %b expected 1818 1 0",
               {op_low, op_high}, done, err);
    end
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mov_after: ops %h busy %b done %b expected 0000 0 0",
               {op_low, op_high}, busy, done);
    end
  endtask

  task automatic test_half();
    regs[0] = 8'h3C;
    regs[2] = 8'h00;
    send(CMD_HALF, 3'd0, 3'd2, 1'b0, 1'b1);
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h0210 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL half_cycle: ops %h done %b expected 0210 1", {op_low, op_high}, done);
    end
    step();
    vectors++;
    if (regs[2] !== 8'hC0) begin
      miscompares++;
      $display("FAIL half_data: reg2 got %h expected c0", regs[2]);
    end
    regs[1] = 8'h5A;
    send(CMD_HALF, 3'd1, 3'd1, 1'b0, 1'b1);
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h0804 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL half_same_reg: ops %h done %b expected 0804 1", {op_low, op_high}, done);
    end
    step();
    vectors++;
    if (regs[1] !== 8'hAA) begin
      miscompares++;
      $display("FAIL half_same_data: reg1 got %h expected aa", regs[1]);
    end
  endtask

  task automatic test_noop();
    send(CMD_MOV, 3'd2, 3'd2, 1'b0, 1'b0);
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h0000 || done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL noop_mov: ops %h done %b err %b expected 0000 1 0",
               {op_low, op_high}, done, err);
    end
    send(CMD_HALF, 3'd3, 3'd3, 1'b1, 1'b1);
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h0000 || done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL noop_half: ops %h done %b err %b expected 0000 1 0",
               {op_low, op_high}, done, err);
    end
    step();
  endtask

  task automatic test_swap();
    logic [7:0] exp_ops [4] = '{8'h42, 8'h09, 8'h84, 8'h00};
    logic       exp_done [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    regs[0] = 8'hA5;
    regs[1] = 8'h5A;
    regs[3] = 8'h00;
    send(CMD_SWAP, 3'd0, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (op_low !== exp_ops[i] || op_high !== exp_ops[i] || done !== exp_done[i]) begin
        miscompares++;
        $display("FAIL swap_cycle%0d: low %h high %h done %b expected %h %h %b",
                 i + 1, op_low, op_high, done, exp_ops[i], exp_ops[i], exp_done[i]);
      end
    end
    vectors++;
    if (regs[0] !== 8'h5A || regs[1] !== 8'hA5 || regs[3] !== 8'hA5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL swap_data: r0 %h r1 %h r3 %h busy %b expected 5a a5 a5 0",
               regs[0], regs[1], regs[3], busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] cmds [7] = '{CMD_SWAP, CMD_SWAP, CMD_MOV, CMD_MOV, CMD_MOV, CMD_MOV, CMD_MOV};
    logic [2:0] srcs [7] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd3};
    logic [2:0] dsts [7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd2, 3'd1};
    logic [7:0] mov_ops [5] = '{8'h12, 8'h60, 8'h09, 8'h12, 8'h84};
    logic       rdy_log [14];
    logic       done_log [14];
    logic       busy_log [14];
    logic [7:0] lo_log [14];
    logic [7:0] hi_log [14];
    logic       rdy, vld;
    int idx = 0;
    regs[0] = 8'h11;
    regs[1] = 8'h22;
    regs[2] = 8'h33;
    regs[3] = 8'h44;
    drive(cmds[0], srcs[0], dsts[0], 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      rdy = req_ready;
      vld = req_valid;
      step();
      if (vld && rdy) idx++;
      rdy_log[k]  = req_ready;
      done_log[k] = done;
      busy_log[k] = busy;
      lo_log[k]   = op_low;
      hi_log[k]   = op_high;
      if (idx < 7) drive(cmds[idx], srcs[idx], dsts[idx], 1'b0, 1'b0);
      else req_valid = 1'b0;
    end
    vectors++;
    if ({rdy_log[4], rdy_log[5], rdy_log[6], rdy_log[7]} !== 4'b1001) begin
      miscompares++;
      $display("FAIL b2b_ready: slots4..7 got %b expected 1001",
               {rdy_log[4], rdy_log[5], rdy_log[6], rdy_log[7]});
    end
    vectors++;
    if ({done_log[2], done_log[3], done_log[5], done_log[6]} !== 4'b0101) begin
      miscompares++;
      $display("FAIL b2b_swap_done: slots2,3,5,6 got %b expected 0101",
               {done_log[2], done_log[3], done_log[5], done_log[6]});
    end
    for (int m = 0; m < 5; m++) begin
      vectors++;
      if (lo_log[7+m] !== mov_ops[m] || hi_log[7+m] !== mov_ops[m] || done_log[7+m] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_mov%0d: low %h high %h done %b expected %h %h 1",
                 m + 1, lo_log[7+m], hi_log[7+m], done_log[7+m], mov_ops[m], mov_ops[m]);
      end
    end
    vectors++;
    if (busy_log[12] !== 1'b0 || lo_log[12] !== 8'h00 || idx !== 7) begin
      miscompares++;
      $display("FAIL b2b_end: busy %b ops %h accepted %0d expected 0 00 7",
               busy_log[12], lo_log[12], idx);
    end
    vectors++;
    if ({regs[0], regs[1], regs[2], regs[3]} !== 32'h22112211) begin
      miscompares++;
      $display("FAIL b2b_data: regs got %h expected 22112211",
               {regs[0], regs[1], regs[2], regs[3]});
    end
  endtask

  task automatic test_errors();
    logic [1:0] cmds [5] = '{CMD_ILL, CMD_MOV, CMD_SWAP, CMD_SWAP, CMD_HALF};
    logic [2:0] srcs [5] = '{3'd0, 3'd5, 3'd0, 3'd2, 3'd1};
    logic [2:0] dsts [5] = '{3'd1, 3'd1, 3'd3, 3'd2, 3'd4};
    for (int i = 0; i < 5; i++) begin
      send(cmds[i], srcs[i], dsts[i], 1'b0, 1'b0);
      step();
      vectors++;
      if (err !== 1'b1 || done !== 1'b0 || {op_low, op_high} !== 16'h0000) begin
        miscompares++;
        $display("FAIL err%0d: err %b done %b ops %h expected 1 0 0000",
                 i, err, done, {op_low, op_high});
      end
    end
    step();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: err got %b expected 0", err);
    end
    send(CMD_MOV, 3'd0, 3'd3, 1'b0, 1'b0);
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h4242 || done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_recover: ops %h done %b err %b expected 4242 1 0",
               {op_low, op_high}, done, err);
    end
    step();
  endtask

  task automatic test_reset_mid_swap();
    send(CMD_SWAP, 3'd0, 3'd1, 1'b0, 1'b0);
    drive(CMD_MOV, 3'd1, 3'd2, 1'b0, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h0909) begin
      miscompares++;
      $display("FAIL rst_swap2: ops %h expected 0909", {op_low, op_high});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({op_low, op_high} !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_abort: ops %h busy %b done %b ready %b expected 0000 0 0 1",
               {op_low, op_high}, busy, done, req_ready);
    end
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_flushed: ops %h done %b busy %b expected 0000 0 0",
               {op_low, op_high}, done, busy);
    end
    send(CMD_MOV, 3'd2, 3'd0, 1'b0, 1'b0);
    step();
    vectors++;
    if ({op_low, op_high} !== 16'h2121 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_new_mov: ops %h done %b expected 2121 1", {op_low, op_high}, done);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 4; r++) regs[r] = 8'h00;
    test_reset();
    test_mov();
    test_half();
    test_noop();
    test_swap();
    test_back_to_back();
    test_errors();
    test_reset_mid_swap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
